// File: rtl/vga_pkg.sv
// Shared definitions for the pixel-domain display timing generator:
// default 800x480 timing, the pixel word layout and the run/idle state.
package vga_pkg;

  localparam int HDISP_DEF  = 800;
  localparam int HFP_DEF    = 40;
  localparam int HPULSE_DEF = 48;
  localparam int HBP_DEF    = 40;
  localparam int VDISP_DEF  = 480;
  localparam int VFP_DEF    = 13;
  localparam int VPULSE_DEF = 3;
  localparam int VBP_DEF    = 29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/vga_timing.sv
// Display timing generator: stage-0 line/frame counters drive the FIFO read
// strobe, stage-1 registers produce sync, blank and coordinates one cycle later.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HDISP  = HDISP_DEF,
  parameter int HFP    = HFP_DEF,
  parameter int HPULSE = HPULSE_DEF,
  parameter int HBP    = HBP_DEF,
  parameter int VDISP  = VDISP_DEF,
  parameter int VFP    = VFP_DEF,
  parameter int VPULSE = VPULSE_DEF,
  parameter int VBP    = VBP_DEF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_rdata,
  output logic        fifo_rd,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic [23:0] VGA_RGB,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        underflow
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_PSTART = HW'(HFP);
  localparam logic [HW-1:0] H_PEND   = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_START  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_PSTART = VW'(VFP);
  localparam logic [VW-1:0] V_PEND   = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_START  = VW'(VFP + VPULSE + VBP);

  if (HDISP >= 2048 || VDISP >= 1024) begin : g_bad_params
    $error("vga_timing: HDISP must be below 2048 and VDISP below 1024");
  end

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          line_end, frame_end;

  assign line_end  = (hcnt_q == H_LAST);
  assign frame_end = line_end && (vcnt_q == V_LAST);

  // en is only looked at in IDLE or on the last cycle of a frame, so a
  // frame that has started always runs to completion.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (line_end) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
        if (frame_end && !en) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // ---- stage 0: decode from the counters ----
  logic          run_p0, vld_p0, hs_p0, vs_p0;
  logic [HW-1:0] hoff_p0;
  logic [VW-1:0] voff_p0;

  assign run_p0  = (state_q == RUN);
  assign vld_p0  = run_p0 && (hcnt_q >= H_START) && (vcnt_q >= V_START);
  assign hs_p0   = !(run_p0 && (hcnt_q >= H_PSTART) && (hcnt_q < H_PEND));
  assign vs_p0   = !(run_p0 && (vcnt_q >= V_PSTART) && (vcnt_q < V_PEND));
  assign hoff_p0 = hcnt_q - H_START;
  assign voff_p0 = vcnt_q - V_START;
  assign fifo_rd = vld_p0;

  // ---- stage 1: registered timing outputs ----
  logic        hs_p1_q, vs_p1_q, vld_p1_q, uf_q;
  logic [10:0] x_p1_q;
  logic [9:0]  y_p1_q;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      vld_p1_q <= 1'b0;
      x_p1_q   <= '0;
      y_p1_q   <= '0;
      uf_q     <= 1'b0;
    end else begin
      hs_p1_q  <= hs_p0;
      vs_p1_q  <= vs_p0;
      vld_p1_q <= vld_p0;
      x_p1_q   <= vld_p0 ? 11'(hoff_p0) : 11'd0;
      y_p1_q   <= vld_p0 ? 10'(voff_p0) : 10'd0;
      uf_q     <= uf_q | (vld_p0 & fifo_empty);
    end
  end

  // FIFO data already arrives one cycle after the read, i.e. in stage 1,
  // so it is gated rather than registered again to stay aligned with BLANK.
  rgb_t pix_p1;
  assign pix_p1 = rgb_t'(fifo_rdata);

  assign VGA_HS    = hs_p1_q;
  assign VGA_VS    = vs_p1_q;
  assign VGA_BLANK = vld_p1_q;
  assign VGA_RGB   = vld_p1_q ? pix_p1 : 24'h0;
  assign x         = x_p1_q;
  assign y         = y_p1_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with a reduced 17x10 raster: directed table of
// timing points plus randomized en/empty/reset traffic against a frame model.
module tb_vga_timing;
  localparam int HFP = 3, HPULSE = 4, HBP = 2, HDISP = 8;
  localparam int VFP = 2, VPULSE = 2, VBP = 1, VDISP = 5;
  localparam int HT = HFP + HPULSE + HBP + HDISP;
  localparam int VT = VFP + VPULSE + VBP + VDISP;
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int FRAME = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b0;
  logic [23:0] fifo_rdata = 24'h0;
  logic        fifo_rd, VGA_HS, VGA_VS, VGA_BLANK, underflow;
  logic [23:0] VGA_RGB;
  logic [10:0] x;
  logic [9:0]  y;

  vga_timing #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .en(en),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .VGA_RGB(VGA_RGB), .x(x), .y(y), .underflow(underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: position is a cycle index t within the frame; line/row and
  // all outputs follow from t by division. Outputs lag the decode by a cycle.
  bit m_run = 0, m_synced = 0;
  int m_t = 0;
  bit e_hs = 1, e_vs = 1, e_bl = 0, e_uf = 0;
  int e_x = 0, e_y = 0;

  initial begin : ref_model
    forever begin : cyc
      int h, v;
      bit rd;
      @(negedge pixel_clk);
      h  = m_t % HT;
      v  = m_t / HT;
      rd = m_run && h >= HSTART && v >= VSTART;
      if (m_synced) begin
        chk("m_fifo_rd", fifo_rd, rd);
        chk("m_hs", VGA_HS, e_hs);
        chk("m_vs", VGA_VS, e_vs);
        chk("m_blank", VGA_BLANK, e_bl);
        chk("m_x", x, e_x);
        chk("m_y", y, e_y);
        chk("m_underflow", underflow, e_uf);
        chk("m_rgb", VGA_RGB, e_bl ? fifo_rdata : 24'h0);
      end
      if (pixel_rst) begin
        m_run = 0; m_t = 0; m_synced = 1;
        e_hs = 1; e_vs = 1; e_bl = 0; e_x = 0; e_y = 0; e_uf = 0;
      end else begin
        e_hs = !(m_run && h >= HFP && h < HFP + HPULSE);
        e_vs = !(m_run && v >= VFP && v < VFP + VPULSE);
        e_bl = rd;
        e_x  = rd ? h - HSTART : 0;
        e_y  = rd ? v - VSTART : 0;
        e_uf = e_uf | (rd & fifo_empty);
        if (!m_run) begin
          m_run = en; m_t = 0;
        end else if (m_t == FRAME - 1) begin
          m_run = en; m_t = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    fifo_rdata = 24'($urandom());
  endtask

  typedef struct {
    int k;
    bit rd, hs, vs, bl;
    int xx, yy;
    bit uf;
  } vec_t;

  vec_t tbl[$];
  int   nreads;

  initial begin : wd
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    // k: rd hs vs bl x y uf  (k = cycles since RUN entry)
    tbl = '{
      '{0,   0,1,1,0, 0,0,0}, '{3,   0,1,1,0, 0,0,0}, '{4,   0,0,1,0, 0,0,0},
      '{7,   0,0,1,0, 0,0,0}, '{8,   0,1,1,0, 0,0,0}, '{34,  0,1,1,0, 0,0,0},
      '{35,  0,1,0,0, 0,0,0}, '{68,  0,1,0,0, 0,0,0}, '{69,  0,1,1,0, 0,0,0},
      '{94,  1,1,1,0, 0,0,0}, '{95,  1,1,1,1, 0,0,0}, '{102, 0,1,1,1, 7,0,0},
      '{103, 0,1,1,0, 0,0,0}, '{113, 1,1,1,1, 1,1,0}, '{169, 1,1,1,1, 6,4,0},
      '{170, 0,1,1,1, 7,4,0}, '{174, 0,0,1,0, 0,0,0}, '{303, 1,1,1,1, 4,2,0},
      '{304, 1,1,1,1, 5,2,1}, '{339, 1,1,1,1, 6,4,1}, '{340, 0,1,1,1, 7,4,1},
      '{341, 0,1,1,0, 0,0,1}, '{360, 0,1,1,0, 0,0,1}
    };

    // reset, then idle with en low
    repeat (3) tick();
    pixel_rst = 0;
    @(negedge pixel_clk);
    chk("rst_hs", VGA_HS, 1); chk("rst_vs", VGA_VS, 1);
    chk("rst_blank", VGA_BLANK, 0); chk("rst_rgb", VGA_RGB, 0);
    chk("rst_x", x, 0); chk("rst_y", y, 0);
    chk("rst_underflow", underflow, 0); chk("rst_fifo_rd", fifo_rd, 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      @(negedge pixel_clk);
      chk("idle_rd", fifo_rd, 0); chk("idle_hs", VGA_HS, 1);
      chk("idle_vs", VGA_VS, 1); chk("idle_blank", VGA_BLANK, 0);
      chk("idle_rgb", VGA_RGB, 0);
    end

    // two frames: table points, underflow at (5,2) of frame 2, en dropped mid-frame 2
    tick();
    en = 1;
    tick();
    nreads = 0;
    for (int k = 0, idx = 0; k <= 360; k++) begin
      en = (k < 220);
      fifo_empty = (k == 303);
      @(negedge pixel_clk);
      if (k < FRAME && fifo_rd) nreads++;
      if (idx < tbl.size() && tbl[idx].k == k) begin
        chk("tbl_fifo_rd", fifo_rd, tbl[idx].rd);
        chk("tbl_hs", VGA_HS, tbl[idx].hs);
        chk("tbl_vs", VGA_VS, tbl[idx].vs);
        chk("tbl_blank", VGA_BLANK, tbl[idx].bl);
        chk("tbl_x", x, tbl[idx].xx);
        chk("tbl_y", y, tbl[idx].yy);
        chk("tbl_underflow", underflow, tbl[idx].uf);
        idx++;
      end
      tick();
    end
    fifo_empty = 0;
    chk("reads_per_frame", nreads, HDISP * VDISP);

    // reset asserted mid-line in an active row
    en = 1;
    tick();
    for (int k = 0; k < 100; k++) begin
      fifo_empty = (k == 96);
      pixel_rst  = (k == 97);
      @(negedge pixel_clk);
      if (k == 97) chk("pre_rst_underflow", underflow, 1);
      if (k == 98) begin
        chk("midrst_hs", VGA_HS, 1); chk("midrst_vs", VGA_VS, 1);
        chk("midrst_blank", VGA_BLANK, 0); chk("midrst_rgb", VGA_RGB, 0);
        chk("midrst_x", x, 0); chk("midrst_y", y, 0);
        chk("midrst_underflow", underflow, 0); chk("midrst_fifo_rd", fifo_rd, 0);
      end
      tick();
    end
    pixel_rst  = 0;
    fifo_empty = 0;

    // randomized en / empty / occasional reset, checked by the frame model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      fifo_empty = ($urandom_range(0, 59) == 0);
      pixel_rst  = ($urandom_range(0, 799) == 0);
      tick();
    end
    pixel_rst = 0;
    @(negedge pixel_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
